// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage of the 5-stage WISC pipeline.
//
// Owns the PC, drives the instruction-memory request/done handshake and loads the IF/ID
// register (instr, PC_inc, IFID_valid). Redirects (PCsrc/flush/PC_new) come back from decode.
// Stall, halt and discard of in-flight responses are handled here, so decode only ever sees a
// valid instruction or a NOP bubble.
//
// Parameters:
//   RESET_PC   - PC loaded on reset
//   NOP_INSTR  - bubble word inserted into IF/ID
//
// Ports:
//   clk, rst                   - clock, asynchronous active-low reset
//   stall                      - hold IF/ID and PC (PCsrc/flush ignored while set)
//   PCsrc, flush, PC_new       - redirect request, IF/ID squash, redirect target
//   imem_addr, imem_rd         - fetch address (= PC) and request, decoded from registers only
//   imem_data, imem_done,
//   imem_err                   - response word, strobe and fault (fault qualified by done)
//   instr, PC_inc, IFID_valid  - IF/ID pipeline register
//   halted, err                - fetch stopped; sticky fetch error
//
// Optional feature: define FETCH_ALIGN_CHK_EN to trap odd PCs as fetch errors instead of
// issuing the request.
module fetch_stage #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = 16'h0800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        PCsrc,
   input  logic        flush,
   input  logic [15:0] PC_new,
   output logic [15:0] imem_addr,
   output logic        imem_rd,
   input  logic [15:0] imem_data,
   input  logic        imem_done,
   input  logic        imem_err,
   output logic [15:0] instr,
   output logic [15:0] PC_inc,
   output logic        IFID_valid,
   output logic        halted,
   output logic        err
);

   typedef enum logic [1:0] {
      StFetch,
      StHold,
      StDrain,
      StHalted
   } state_e;

   state_e      state_q;
   logic [15:0] pc_q;
   logic [15:0] hold_q;     // word captured while stalled
   logic [15:0] pc_plus2;
   logic        redirect;
   logic        misaligned;

   assign pc_plus2 = pc_q + 16'd2;   // wraps modulo 2^16
   assign redirect = PCsrc & ~stall;

`ifdef FETCH_ALIGN_CHK_EN
   assign misaligned = pc_q[0];
`else
   assign misaligned = 1'b0;
`endif

   assign imem_addr = pc_q;
   assign imem_rd   = (state_q == StFetch) & ~misaligned;
   assign halted    = (state_q == StHalted);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StFetch;
         pc_q       <= RESET_PC;
         hold_q     <= NOP_INSTR;
         instr      <= NOP_INSTR;
         PC_inc     <= 16'h0000;
         IFID_valid <= 1'b0;
         err        <= 1'b0;
      end else begin
         // Redirect wins over advance and halt detection in every state.
         if (redirect) begin
            pc_q   <= PC_new;
            hold_q <= NOP_INSTR;
            if (flush) begin
               instr      <= NOP_INSTR;
               PC_inc     <= 16'h0000;
               IFID_valid <= 1'b0;
            end
         end

         unique case (state_q)
            StFetch: begin
               if (redirect) begin
                  // An unanswered request must be drained before refetching.
                  state_q <= (imem_rd && !imem_done) ? StDrain : StFetch;
               end else if (misaligned) begin
                  err        <= 1'b1;
                  instr      <= NOP_INSTR;
                  PC_inc     <= 16'h0000;
                  IFID_valid <= 1'b0;
                  state_q    <= StHalted;
               end else if (imem_done) begin
                  if (imem_err) begin
                     err        <= 1'b1;
                     instr      <= NOP_INSTR;
                     PC_inc     <= 16'h0000;
                     IFID_valid <= 1'b0;
                     state_q    <= StHalted;
                  end else if (stall) begin
                     hold_q  <= imem_data;
                     state_q <= StHold;
                  end else begin
                     instr      <= imem_data;
                     PC_inc     <= pc_plus2;
                     IFID_valid <= 1'b1;
                     // HALT (opcode 0) is delivered but the PC stays on it.
                     if (imem_data[15:11] == 5'b00000) begin
                        state_q <= StHalted;
                     end else begin
                        pc_q <= pc_plus2;
                     end
                  end
               end
            end

            StHold: begin
               if (redirect) begin
                  state_q <= StFetch;
               end else if (!stall) begin
                  instr      <= hold_q;
                  PC_inc     <= pc_plus2;
                  IFID_valid <= 1'b1;
                  if (hold_q[15:11] == 5'b00000) begin
                     state_q <= StHalted;
                  end else begin
                     pc_q    <= pc_plus2;
                     state_q <= StFetch;
                  end
               end
            end

            StDrain: begin
               // The stale response is dropped; a redirect here only moved the PC above.
               if (imem_done) begin
                  state_q <= StFetch;
               end
            end

            StHalted: begin
               if (redirect) begin
                  state_q <= StFetch;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the 5-stage WISC pipeline. It is the producer side of the IF/ID interface consumed by `decode`. It owns the PC register and drives an instruction-memory request/done handshake. It loads the IF/ID pipeline register (`instr`, `PC_inc`) and applies the `PC_new`/`PCsrc`/`flush` redirect that `decode` returns. Stall, halt and in-flight-response discard are handled here so that `decode` only ever sees a valid instruction or a NOP.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `NOP_INSTR`, 16'h0800, bubble word (opcode 5'b00001) inserted into IF/ID.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard unit holds IF/ID and PC.
- `PCsrc`  in  1  redirect request from decode.
- `flush`  in  1  squash IF/ID contents.
- `PC_new`  in  16  redirect target.
- `imem_addr`  out  16  fetch address, equal to current PC.
- `imem_rd`  out  1  fetch request, held until `imem_done`.
- `imem_data`  in  16  instruction word; valid when `imem_done`=1.
- `imem_done`  in  1  response strobe; may be asserted in the same cycle as `imem_rd`.
- `imem_err`  in  1  memory fault; qualified by `imem_done`.
- `instr`  out  16  IF/ID instruction.
- `PC_inc`  out  16  IF/ID PC+2 of `instr`.
- `IFID_valid`  out  1  IF/ID holds a real instruction.
- `halted`  out  1  fetch stopped on HALT or error.
- `err`  out  1  sticky fetch error.

## Operation
- State machine: FETCH, HOLD, DRAIN, HALTED.
- FETCH:
  - `imem_rd`=1, `imem_addr`=PC.
  - On `imem_done` with `stall`=0: IF/ID <= {`imem_data`, PC+2}, `IFID_valid`<=1, PC<=PC+2.
  - On `imem_done` with `stall`=1: word goes into a one-entry hold buffer, then to HOLD.
- HOLD:
  - `imem_rd`=0, IF/ID unchanged.
  - When `stall` falls: load the buffer into IF/ID, PC<=PC+2, go to FETCH.
- Redirect: `PCsrc`=1 and `stall`=0. `PCsrc`/`flush` are ignored while `stall`=1.
  - PC<=`PC_new`.
  - If `flush`, IF/ID <= {`NOP_INSTR`, 16'h0000} and `IFID_valid`<=0. The hold buffer is cleared.
  - A response arriving in the same cycle is discarded.
  - If a request is outstanding without `imem_done`, go to DRAIN.
  - Redirect takes priority over the normal advance and over HALT detection.
- DRAIN:
  - `imem_rd`=0.
  - The next `imem_done` is discarded, then go to FETCH at the redirected PC.
  - A further redirect while in DRAIN only updates PC.
- HALT:
  - A fetched word with opcode 5'b00000 is loaded into IF/ID normally.
  - PC is not advanced; go to HALTED.
- HALTED:
  - `imem_rd`=0, `halted`=1.
  - Exit to FETCH only on redirect or reset.
- Error: `imem_done`&`imem_err` sets `err`=1 (sticky until reset), loads NOP into IF/ID, goes to HALTED.
- Arithmetic: PC+2 is modulo 2^16; 16'hFFFE advances to 16'h0000 without error.

## Timing
- Reset values: PC=`RESET_PC`, `instr`=`NOP_INSTR`, `PC_inc`=0, `IFID_valid`=0, `halted`=0, `err`=0, state FETCH.
- In the first cycle after reset release, `imem_rd`=1.
- `imem_addr` and `imem_rd` are decoded from registered state only, with no combinational path from `imem_done`.
- IF/ID is updated at the edge sampling `imem_done`, so `instr` is visible 1 cycle after the done strobe.
- With a zero-wait memory (done every cycle), throughput is 1 instruction/cycle.
- Redirect: the `PC_new` fetch issues on the first cycle after the redirect edge (FETCH), or on the cycle after the drained `imem_done` (DRAIN).
- Reset asserted mid-request: the in-flight response after release is not tracked. Memory must be reset alongside this block.

## Configuration
- `FETCH_ALIGN_CHK_EN` defined:
  - In FETCH with PC[0]=1, no request is issued (`imem_rd`=0).
  - `err`<=1, IF/ID <= NOP, go to HALTED.
- Undefined: PC[0] is passed to `imem_addr` unchecked and no alignment error exists.

## Test plan
- Reset, zero-wait memory returning 16'h4000+addr:
  - `imem_addr` sequence 0,2,4.
  - `instr` sequence 16'h4000, 16'h4002 with `PC_inc` 2, 4.
  - `IFID_valid`=1 from the second cycle.
- `stall`=1 for 3 cycles in the cycle of a done at PC=6:
  - IF/ID is frozen.
  - After `stall` falls, `instr`=word@6, then PC=8 is requested.
- Memory with 3-cycle latency, `PCsrc`=`flush`=1, `PC_new`=16'h0040 during a pending request:
  - The late response is dropped and `instr`=16'h0800, `IFID_valid`=0.
  - Next `imem_addr`=16'h0040.
- Word 16'h0000 at PC=10:
  - `instr`=16'h0000, `halted`=1, `imem_rd`=0.
  - PC stays at 10 for 20 cycles.
  - Then a redirect to 16'h0020 resumes fetch.
- `imem_err`=1 with done: `err`=1, `instr`=16'h0800, `halted`=1. `err` persists until `rst`=0.
- With `FETCH_ALIGN_CHK_EN`, redirect to 16'h0013: no request, `err`=1. Without the macro, `imem_addr`=16'h0013.
